// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session FSM with PIN retries, card retention, checked balance arithmetic and inactivity timeout
module atm_session_ctrl #(
  parameter int BAL_W = 32,
  parameter int AMT_W = 16,
  parameter int PIN_W = 4,
  parameter logic [PIN_W-1:0] PIN_VALUE = 4'b1010,
  parameter logic [BAL_W-1:0] INIT_BAL = 32'h000F4240,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cardIn,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [AMT_W-1:0] amount,
  output logic [BAL_W-1:0] balance,
  output logic             done,
  output logic [2:0]       status,
  output logic             card_eject,
  output logic             card_retained,
  output logic             session_active
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] ST_OK = 3'd0, ST_BAD_PIN = 3'd1, ST_INSUFF = 3'd2, ST_OVF = 3'd3, ST_TIMEOUT = 3'd4, ST_RETAINED = 3'd5;
  typedef enum logic [2:0] {S_IDLE, S_PIN, S_MENU, S_EXEC, S_REPORT, S_EJECT, S_RETAIN} state_t;
  state_t state;
  logic card_q;
  logic [TRY_W-1:0] tries;
  logic [TMR_W-1:0] timer;
  logic [1:0] op_q;
  logic [BAL_W-1:0] amt_q;
  logic [BAL_W:0] sum;
  logic timed_out;
  assign sum = {1'b0, balance} + {1'b0, amt_q};
  assign timed_out = timer == TMR_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      card_q <= 1'b0;
      tries <= '0;
      timer <= '0;
      op_q <= 2'b00;
      amt_q <= '0;
      balance <= INIT_BAL;
      done <= 1'b0;
      status <= ST_OK;
      card_eject <= 1'b0;
      card_retained <= 1'b0;
      session_active <= 1'b0;
    end else begin
      card_q <= cardIn;
      done <= 1'b0;
      card_eject <= 1'b0;
      case (state)
        S_IDLE: if (cardIn && !card_q) begin
          state <= S_PIN;
          tries <= '0;
          timer <= '0;
          session_active <= 1'b1;
        end
        S_PIN: if (!cardIn) begin
          state <= S_IDLE;
          session_active <= 1'b0;
        end else if (pin_valid) begin
          timer <= '0;
          if (pin == PIN_VALUE) state <= S_MENU;
          else begin
            done <= 1'b1;
            tries <= tries + 1'b1;
            if (tries == TRY_W'(MAX_TRIES - 1)) begin
              state <= S_RETAIN;
              status <= ST_RETAINED;
              card_retained <= 1'b1;
              session_active <= 1'b0;
            end else status <= ST_BAD_PIN;
          end
        end else if (timed_out) begin
          state <= S_EJECT;
          done <= 1'b1;
          status <= ST_TIMEOUT;
          card_eject <= 1'b1;
          session_active <= 1'b0;
        end else timer <= timer + 1'b1;
        S_MENU: if (!cardIn) begin
          state <= S_IDLE;
          session_active <= 1'b0;
        end else if (op_valid) begin
          timer <= '0;
          if (op_code == 2'b11) begin
            state <= S_EJECT;
            done <= 1'b1;
            status <= ST_OK;
            card_eject <= 1'b1;
            session_active <= 1'b0;
          end else begin
            state <= S_EXEC;
            op_q <= op_code;
            amt_q <= BAL_W'(amount);
          end
        end else if (timed_out) begin
          state <= S_EJECT;
          done <= 1'b1;
          status <= ST_TIMEOUT;
          card_eject <= 1'b1;
          session_active <= 1'b0;
        end else timer <= timer + 1'b1;
        S_EXEC: begin
          state <= S_REPORT;
          done <= 1'b1;
          if (op_q == 2'b01) begin
            status <= sum[BAL_W] ? ST_OVF : ST_OK;
            if (!sum[BAL_W]) balance <= sum[BAL_W-1:0];
          end else if (op_q == 2'b10) begin
            status <= (amt_q > balance) ? ST_INSUFF : ST_OK;
            if (amt_q <= balance) balance <= balance - amt_q;
          end else status <= ST_OK;
        end
        S_REPORT: begin
          timer <= '0;
          state <= cardIn ? S_MENU : S_IDLE;
          session_active <= cardIn;
        end
        S_EJECT: state <= S_IDLE;
        S_RETAIN: state <= S_RETAIN;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
